// File: rtl/riscv_dmem_arbiter.sv
// Two-master (CPU/DBG) arbiter for the shared data-memory port, with starvation guard and read-owner tagging.
// Optional address range checking is enabled by defining DMEM_ARB_RANGE_CHECK_EN.
module riscv_dmem_arbiter #(
    parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
    parameter int unsigned DATA_BRAMS         = 2,
    parameter int unsigned MAX_WAIT           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dmem_addr,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] rdata
`ifdef DMEM_ARB_RANGE_CHECK_EN
    ,
    output logic        range_err,
    output logic [15:0] err_count
`endif
);

    localparam int unsigned DATA_ADDR_BITS = 11 + DATA_BRAMS;
    localparam int unsigned WW             = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST    = WW'(MAX_WAIT - 1);
    localparam logic [WW-1:0] WAIT_MAX     = WW'(MAX_WAIT);

    if (MAX_WAIT < 1 || DATA_START_ADDRESS[DATA_ADDR_BITS-1:0] != '0) begin : g_cfg_check
        $error("riscv_dmem_arbiter: MAX_WAIT must be >= 1 and DATA_START_ADDRESS aligned to the data memory size");
    end

    typedef enum logic {S_CPU, S_DBG} state_e;

    state_e          state_q, state_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            cpu_rd_q, cpu_rd_d;
    logic            dbg_rd_q, dbg_rd_d;
    logic            acc_we;
    logic            issue;
    logic            strobe_en;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic            addr_ok;
    logic            rd_err_q, rd_err_d;
    logic [15:0]     err_count_q, err_count_d;
`endif

    // Grants are combinational and forced low while reset is asserted.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst) begin
            if (state_q == S_DBG) begin
                dbg_gnt = dbg_req;
                cpu_gnt = cpu_req & ~dbg_req;
            end else begin
                cpu_gnt = cpu_req;
                dbg_gnt = dbg_req & ~cpu_req;
            end
        end
    end

    always_comb begin
        dmem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
        dmem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
        acc_we     = dbg_gnt ? dbg_we    : cpu_we;
        issue      = cpu_gnt | dbg_gnt;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        addr_ok    = (dmem_addr[31:DATA_ADDR_BITS] == DATA_START_ADDRESS[31:DATA_ADDR_BITS]);
        range_err  = issue & ~addr_ok;
        strobe_en  = issue & addr_ok;
`else
        strobe_en  = issue;
`endif
        dmem_read  = strobe_en & ~acc_we;
        dmem_write = strobe_en & acc_we;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        if (dbg_req && !dbg_gnt) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
        end
        case (state_q)
            S_CPU: if (dbg_req && !dbg_gnt && wait_cnt_q == WAIT_LAST) state_d = S_DBG;
            S_DBG: if (dbg_gnt || !dbg_req) state_d = S_CPU;
            default: state_d = S_CPU;
        endcase
        cpu_rd_d = cpu_gnt & ~cpu_we;
        dbg_rd_d = dbg_gnt & ~dbg_we;
`ifdef DMEM_ARB_RANGE_CHECK_EN
        rd_err_d    = range_err & ~acc_we;
        err_count_d = err_count_q;
        if (range_err && err_count_q != '1) err_count_d = err_count_q + 16'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_CPU;
            wait_cnt_q  <= '0;
            cpu_rd_q    <= 1'b0;
            dbg_rd_q    <= 1'b0;
`ifdef DMEM_ARB_RANGE_CHECK_EN
            rd_err_q    <= 1'b0;
            err_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rd_q    <= cpu_rd_d;
            dbg_rd_q    <= dbg_rd_d;
`ifdef DMEM_ARB_RANGE_CHECK_EN
            rd_err_q    <= rd_err_d;
            err_count_q <= err_count_d;
`endif
        end
    end

    assign cpu_rvalid = cpu_rd_q;
    assign dbg_rvalid = dbg_rd_q;

`ifdef DMEM_ARB_RANGE_CHECK_EN
    // An out-of-range read never reached memory, so its return slot carries zero.
    assign rdata     = rd_err_q ? '0 : dmem_rdata;
    assign err_count = err_count_q;
`else
    assign rdata = dmem_rdata;
`endif

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Self-checking bench for riscv_dmem_arbiter: reference model checked every cycle plus directed literal checks.
module tb_riscv_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0] dbg_addr = 32'h0, dbg_wdata = 32'h0;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, rdata;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_rdata;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    logic        range_err;
    logic [15:0] err_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_dmem_arbiter #(
        .DATA_START_ADDRESS(32'h00800000),
        .DATA_BRAMS(2),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
        .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .rdata(rdata)
`ifdef DMEM_ARB_RANGE_CHECK_EN
        , .range_err(range_err), .err_count(err_count)
`endif
    );

    // Preloaded memory contents: word index tagged with 0x5A in the top byte.
    function automatic logic [31:0] pre(input logic [9:0] idx);
        return 32'h5A000000 | {22'b0, idx};
    endfunction

    // Synchronous memory behind the arbiter.
    logic [31:0] mem [0:1023];
    bit   [1023:0] mem_wr;
    logic [9:0]  widx;
    assign widx = dmem_addr[11:2];
    always @(posedge clk) begin
        if (dmem_write) begin
            mem[widx]    <= dmem_wdata;
            mem_wr[widx] <= 1'b1;
        end
        if (dmem_read) dmem_rdata <= mem_wr[widx] ? mem[widx] : pre(widx);
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:1023];
    bit   [1023:0] ref_wr;
    int          m_streak;      // consecutive cycles DBG asked and was refused
    bit          m_boost;       // DBG currently has priority
    int          m_pend;        // 0 none, 1 cpu, 2 dbg read returns this cycle
    logic [31:0] m_pend_data;
    int          m_errs;
    logic        e_cg, e_dg, e_we, e_ok;
    logic [31:0] e_addr, e_wdata;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[11:2]] ? ref_mem[a[11:2]] : pre(a[11:2]);
    endfunction

    function automatic logic in_range(input logic [31:0] a);
`ifdef DMEM_ARB_RANGE_CHECK_EN
        return (a >> 13) == (32'h00800000 >> 13);
`else
        return (a == a);
`endif
    endfunction

    initial begin
        e_cg = 1'b0; e_dg = 1'b0; e_we = 1'b0; e_ok = 1'b1;
        e_addr = 32'h0; e_wdata = 32'h0;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_streak <= 0; m_boost <= 1'b0; m_pend <= 0; m_pend_data <= 32'h0; m_errs <= 0;
        end else begin
            m_streak <= (dbg_req && !e_dg) ? ((m_streak < MAX_WAIT) ? m_streak + 1 : MAX_WAIT) : 0;
            m_boost  <= m_boost ? (dbg_req && !e_dg) : (dbg_req && !e_dg && m_streak + 1 >= MAX_WAIT);
            m_pend   <= (e_cg && !e_we) ? 1 : (e_dg && !e_we) ? 2 : 0;
            m_pend_data <= e_ok ? ref_rd(e_addr) : 32'h0;
            if ((e_cg || e_dg) && e_we && e_ok) begin
                ref_mem[e_addr[11:2]] <= e_wdata;
                ref_wr[e_addr[11:2]]  <= 1'b1;
            end
            if ((e_cg || e_dg) && !e_ok && m_errs < 65535) m_errs <= m_errs + 1;
        end
    end

    // Per-cycle compare: inputs settle at the falling edge, outputs checked 3 units later.
    initial forever begin
        @(negedge clk);
        #3;
        if (!rst) begin
            e_cg = 1'b0; e_dg = 1'b0; e_we = 1'b0; e_ok = 1'b1;
            check1("model rst cpu_gnt", cpu_gnt, 1'b0);
            check1("model rst dbg_gnt", dbg_gnt, 1'b0);
            check1("model rst dmem_read", dmem_read, 1'b0);
            check1("model rst dmem_write", dmem_write, 1'b0);
            check1("model rst cpu_rvalid", cpu_rvalid, 1'b0);
            check1("model rst dbg_rvalid", dbg_rvalid, 1'b0);
        end else begin
            if (m_boost) begin
                e_dg = dbg_req; e_cg = cpu_req && !dbg_req;
            end else begin
                e_cg = cpu_req; e_dg = dbg_req && !cpu_req;
            end
            e_addr  = e_dg ? dbg_addr  : cpu_addr;
            e_wdata = e_dg ? dbg_wdata : cpu_wdata;
            e_we    = e_dg ? dbg_we    : cpu_we;
            e_ok    = in_range(e_addr);
            check1("model cpu_gnt", cpu_gnt, e_cg);
            check1("model dbg_gnt", dbg_gnt, e_dg);
            check32("model dmem_addr", dmem_addr, e_addr);
            check1("model dmem_read", dmem_read, (e_cg || e_dg) && !e_we && e_ok);
            check1("model dmem_write", dmem_write, (e_cg || e_dg) && e_we && e_ok);
            if ((e_cg || e_dg) && e_we) check32("model dmem_wdata", dmem_wdata, e_wdata);
            check1("model cpu_rvalid", cpu_rvalid, m_pend == 1);
            check1("model dbg_rvalid", dbg_rvalid, m_pend == 2);
            if (m_pend != 0) check32("model rdata", rdata, m_pend_data);
`ifdef DMEM_ARB_RANGE_CHECK_EN
            check1("model range_err", range_err, (e_cg || e_dg) && !e_ok);
            check32("model err_count", {16'h0, err_count}, 32'(m_errs));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic [6:0] pat;

    initial begin
        // Reset holds grants off even with a pending request.
        drive(1'b1, 1'b0, 32'h00800010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        check1("reset cpu_gnt", cpu_gnt, 1'b0);
        check1("reset dmem_read", dmem_read, 1'b0);
        check1("reset cpu_rvalid", cpu_rvalid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #4;
        check1("release cpu_gnt", cpu_gnt, 1'b1);
        check1("release dmem_read", dmem_read, 1'b1);

        // CPU read then DBG read in consecutive cycles.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00800020, 32'h0);
        #4;
        check1("rd cpu_rvalid", cpu_rvalid, 1'b1);
        check32("rd cpu rdata", rdata, 32'h5A000004);
        check1("rd dbg_gnt", dbg_gnt, 1'b1);
        idle();
        #4;
        check1("rd dbg_rvalid", dbg_rvalid, 1'b1);
        check1("rd cpu_rvalid low", cpu_rvalid, 1'b0);
        check32("rd dbg rdata", rdata, 32'h5A000008);

        // Contention: DBG refused four cycles, served on the fifth, then CPU again.
        pat = 7'b0010000;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 1'b0, 32'h00800040, 32'h0, 1'b1, 1'b0, 32'h00800080, 32'h0);
            #4;
            check1("contention dbg_gnt", dbg_gnt, pat[k]);
            check1("contention cpu_gnt", cpu_gnt, ~pat[k]);
        end

        // DBG write then CPU read of the same word.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00800004, 32'hDEADBEEF);
        #4;
        check1("wr dbg_gnt", dbg_gnt, 1'b1);
        check1("wr dmem_write", dmem_write, 1'b1);
        drive(1'b1, 1'b0, 32'h00800004, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        check1("wr dbg_rvalid none", dbg_rvalid, 1'b0);
        idle();
        #4;
        check1("raw cpu_rvalid", cpu_rvalid, 1'b1);
        check32("raw rdata", rdata, 32'hDEADBEEF);

        // Back-to-back reads with alternating owners, then CPU write/read.
        drive(1'b1, 1'b0, 32'h00800100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00800104, 32'h0);
        drive(1'b1, 1'b0, 32'h00800108, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        check1("b2b dbg_rvalid", dbg_rvalid, 1'b1);
        check32("b2b rdata", rdata, 32'h5A000041);
        drive(1'b1, 1'b1, 32'h00800200, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 32'h00800200, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle();
        #4;
        check32("cpu raw rdata", rdata, 32'hCAFEF00D);

        // Reset right after a CPU read grant discards the return.
        drive(1'b1, 1'b0, 32'h00800010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        check1("rstmid cpu_gnt", cpu_gnt, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        #4;
        check1("rstmid cpu_rvalid", cpu_rvalid, 1'b0);
        idle();
        rst = 1'b1;
        #4;
        check1("rstmid after release", cpu_rvalid, 1'b0);
        idle();
        #4;
        check1("rstmid later", cpu_rvalid, 1'b0);

`ifdef DMEM_ARB_RANGE_CHECK_EN
        drive(1'b1, 1'b1, 32'h10000000, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
        #4;
        check1("range cpu_gnt", cpu_gnt, 1'b1);
        check1("range dmem_write", dmem_write, 1'b0);
        check1("range_err pulse", range_err, 1'b1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h00900000, 32'h0);
        #4;
        check32("range err_count", {16'h0, err_count}, 32'd1);
        check1("range dbg dmem_read", dmem_read, 1'b0);
        idle();
        #4;
        check1("range dbg_rvalid", dbg_rvalid, 1'b1);
        check32("range rdata zero", rdata, 32'h0);
        check1("range_err clear", range_err, 1'b0);
`endif

        idle();
        idle();
        #4;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
